// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
//  Module  : cp0
//  Brief   : MIPS coprocessor-0 (SR/Cause/EPC/PRId), exception and interrupt
//            entry, mfc0/mtc0 access and eret EXL clear at the M stage.
//  Rev     : 1.0  initial release
// ============================================================================
module cp0 #(
    parameter logic [31:0] PRID_VAL = 32'h2017_1226
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic        ExceptionM,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic        int_pend;
    logic        exc_take;
    logic [31:0] victim_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    always_comb begin
        int_pend   = (|(HWInt & im)) & ie & ~exl;
        exc_take   = ExceptionM & ~exl;
        victim_pc  = {PC[31:2], 2'b00};
        sr_word    = {16'b0, im, 8'b0, exl, ie};
        cause_word = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    end

    assign IntReq = int_pend | exc_take;
    assign EPC    = epc;

    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= 6'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= 6'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= HWInt;
            if (IntReq) begin
                exl      <= 1'b1;
                bd       <= BD;
                epc      <= BD ? (victim_pc - 32'd4) : victim_pc;
                exc_code <= int_pend ? 5'd0 : ExcCode;
            end else begin
                if (We && (A2 == REG_SR)) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (We && (A2 == REG_EPC)) begin
                    epc <= {DIn[31:2], 2'b00};
                end
                // eret clear overrides an EXL value written by mtc0 this cycle
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
//  Module  : tb_cp0
//  Brief   : Self-checking bench for cp0 against a word-level register model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_cp0;

    localparam logic [31:0] PRID = 32'h2017_1226;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  A1 = 5'd0;
    logic [4:0]  A2 = 5'd0;
    logic [31:0] DIn = 32'd0;
    logic        We = 1'b0;
    logic [31:0] PC = 32'd0;
    logic        BD = 1'b0;
    logic [4:0]  ExcCode = 5'd0;
    logic        ExceptionM = 1'b0;
    logic [5:0]  HWInt = 6'd0;
    logic        EXLClr = 1'b0;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int n_checks = 0;
    int n_pass   = 0;

    cp0 #(.PRID_VAL(PRID)) dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
        .PC(PC), .BD(BD), .ExcCode(ExcCode), .ExceptionM(ExceptionM),
        .HWInt(HWInt), .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural register words
    logic [31:0] m_sr = 32'd0, m_cause = 32'd0, m_epc = 32'd0;
    bit          m_valid = 1'b0;

    function automatic logic m_irq();
        logic pend, exc;
        pend = (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
        exc  = ExceptionM && !m_sr[1];
        return pend | exc;
    endfunction

    function automatic logic [31:0] m_dout();
        case (A1)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic pend;
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            pend = (|(HWInt & m_sr[15:10])) && m_sr[0] && !m_sr[1];
            if (m_irq()) begin
                m_sr[1]      = 1'b1;
                m_cause[31]  = BD;
                m_cause[6:2] = pend ? 5'd0 : ExcCode;
                m_epc        = (PC & ~32'd3) - (BD ? 32'd4 : 32'd0);
            end else begin
                if (We && A2 == 5'd12) m_sr  = DIn & 32'h0000_FC03;
                if (We && A2 == 5'd14) m_epc = DIn & ~32'd3;
                if (EXLClr) m_sr[1] = 1'b0;
            end
            m_cause[15:10] = HWInt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("IntReq", {31'd0, IntReq}, {31'd0, m_irq()});
            check("EPC", EPC, m_epc);
            check("DOut", DOut, m_dout());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        We = 0; ExceptionM = 0; EXLClr = 0; HWInt = 0; BD = 0; ExcCode = 0; reset = 0;
    endtask

    initial begin
        // 1: reset
        reset = 1'b1; cyc(); reset = 1'b0;
        A1 = 5'd12; #1 check("rst_sr", DOut, 32'd0);
        A1 = 5'd13; #1 check("rst_cause", DOut, 32'd0);
        A1 = 5'd14; #1 check("rst_epc", DOut, 32'd0);
        A1 = 5'd15; #1 check("rst_prid", DOut, PRID);
        check("rst_intreq", {31'd0, IntReq}, 32'd0);
        cyc();

        // 2: enable IM[10]/IE, then interrupt line 0
        We = 1; A2 = 5'd12; DIn = 32'h0000_0401; cyc();
        We = 0; HWInt = 6'b000001; PC = 32'h0000_1000;
        #1 check("int_req", {31'd0, IntReq}, 32'd1);
        cyc(); HWInt = 0;
        A1 = 5'd12; #1 check("int_sr", DOut, 32'h0000_0403);
        A1 = 5'd13; #1 check("int_cause", DOut, 32'h0000_0400);
        check("int_epc", EPC, 32'h0000_1000);
        cyc();

        // 3: AdEL in a delay slot
        reset = 1; cyc(); reset = 0;
        ExceptionM = 1; ExcCode = 5'd4; PC = 32'h0000_3008; BD = 1;
        #1 check("exc_req", {31'd0, IntReq}, 32'd1);
        cyc(); idle();
        check("exc_epc", EPC, 32'h0000_3004);
        A1 = 5'd13; #1 check("exc_cause", DOut, 32'h8000_0010);
        A1 = 5'd12; #1 check("exc_sr", DOut, 32'h0000_0002);

        // 4: events masked by EXL, then eret lets pending interrupt through
        We = 1; A2 = 5'd12; DIn = 32'h0000_0403; cyc(); We = 0;
        ExceptionM = 1; ExcCode = 5'd5; HWInt = 6'b000001; PC = 32'h0000_5000;
        #1 check("exl_mask", {31'd0, IntReq}, 32'd0);
        cyc(); ExceptionM = 0;
        check("exl_epc", EPC, 32'h0000_3004);
        A1 = 5'd13; #1 check("exl_cause", DOut & ~32'h0000_FC00, 32'h8000_0010);
        EXLClr = 1; cyc(); EXLClr = 0; PC = 32'h0000_6000;
        #1 check("eret_int", {31'd0, IntReq}, 32'd1);
        cyc(); idle();
        check("eret_epc", EPC, 32'h0000_6000);

        // 5: mtc0 EPC suppressed by entry
        reset = 1; cyc(); reset = 0;
        We = 1; A2 = 5'd12; DIn = 32'h0000_0401; cyc();
        HWInt = 6'b000001; A2 = 5'd14; DIn = 32'hDEAD_BEEF; PC = 32'h0000_7004;
        #1 check("sup_req", {31'd0, IntReq}, 32'd1);
        cyc(); idle();
        check("sup_epc", EPC, 32'h0000_7004);

        // 6: mtc0 EPC read-during-write
        reset = 1; cyc(); reset = 0;
        We = 1; A2 = 5'd14; DIn = 32'h0000_3003; A1 = 5'd14;
        #1 check("rdw_old", DOut, 32'd0);
        cyc(); We = 0;
        #1 check("rdw_new", DOut, 32'h0000_3000);
        cyc();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            We         = ($urandom_range(0, 3) == 0);
            A2         = 5'($urandom_range(11, 16));
            A1         = 5'($urandom_range(10, 16));
            DIn        = $urandom;
            PC         = $urandom;
            BD         = 1'($urandom_range(0, 1));
            ExcCode    = 5'($urandom_range(0, 31));
            ExceptionM = ($urandom_range(0, 7) == 0);
            HWInt      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            EXLClr     = ($urandom_range(0, 5) == 0);
            cyc();
        end
        idle();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
